md_scheduler: RTL

- Shares the single multiply/divide unit between two requesters (r0: pipeline E-stage, r1: secondary/coprocessor port).
- Round-robin arbitration, issue, busy-wait sequencing and HI/LO read-back.
- Sits between the requesters and the MDU; drives its start/req/type/operand inputs and consumes its busy/result outputs.

---
 rtl/md_pkg.sv | 19 +
 rtl/md_scheduler_if.sv | 23 ++
 rtl/md_rr_arbiter.sv | 14 +
 rtl/md_scheduler.sv | 82 ++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes shared with the MDU, scheduler state encodings and op helpers.
package md_pkg;
   localparam int OP_W = 4;
   localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
   localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
   localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
   localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
   localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
   localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   function automatic logic is_long_op(input logic [OP_W-1:0] op);
      return op >= OP_MULT && op <= OP_DIVU;
   endfunction
endpackage

// File: rtl/md_scheduler_if.sv
// md_scheduler_if: two requester ports plus the MDU control/result bus.
interface md_scheduler_if #(parameter int OP_W = md_pkg::OP_W);
   logic            flush;
   logic            r0_valid, r0_ready, r0_rsp_valid;
   logic [OP_W-1:0] r0_op;
   logic [31:0]     r0_rs, r0_rt, r0_rsp_data;
   logic            r1_valid, r1_ready, r1_rsp_valid;
   logic [OP_W-1:0] r1_op;
   logic [31:0]     r1_rs, r1_rt, r1_rsp_data;
   logic            mdu_start, mdu_req, mdu_busy;
   logic [OP_W-1:0] mdu_type;
   logic [31:0]     mdu_rs, mdu_rt, mdu_out;
   modport slave (
      input  flush, r0_valid, r0_op, r0_rs, r0_rt, r1_valid, r1_op, r1_rs, r1_rt, mdu_busy, mdu_out,
      output r0_ready, r0_rsp_valid, r0_rsp_data, r1_ready, r1_rsp_valid, r1_rsp_data,
             mdu_start, mdu_req, mdu_type, mdu_rs, mdu_rt
   );
   modport master (
      output flush, r0_valid, r0_op, r0_rs, r0_rt, r1_valid, r1_op, r1_rs, r1_rt, mdu_busy, mdu_out,
      input  r0_ready, r0_rsp_valid, r0_rsp_data, r1_ready, r1_rsp_valid, r1_rsp_data,
             mdu_start, mdu_req, mdu_type, mdu_rs, mdu_rt
   );
endinterface

// File: rtl/md_rr_arbiter.sv
// md_rr_arbiter: two-way grant; alternates on contention unless FIXED_PRIO favours r0.
module md_rr_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       grant
);
   logic last_grant;
   always_comb grant = &req ? (FIXED_PRIO ? 1'b0 : !last_grant) : req[1];
   always_ff @(posedge clk) last_grant <= reset ? 1'b1 : accept ? grant : last_grant;
endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: shares one multiply/divide unit between two requesters.
// Defining MD_SCHED_PERF_EN adds issue/stall performance counters.
module md_scheduler #(
   parameter int OP_W       = md_pkg::OP_W,
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic           clk,
   input logic           reset,
   md_scheduler_if.slave bus
`ifdef MD_SCHED_PERF_EN
   ,
   output logic [31:0]   perf_issue_cnt,
   output logic [31:0]   perf_stall_cnt
`endif
);
   import md_pkg::*;
   logic [1:0]      state, rsp_valid;
   logic            grant, idle_ok, accept, owner;
   logic [OP_W-1:0] sel_op;
   logic [31:0]     sel_rs, sel_rt, rsp_data;
   md_rr_arbiter #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk(clk),
      .reset(reset),
      .req({bus.r1_valid, bus.r0_valid}),
      .accept(accept),
      .grant(grant)
   );
   always_comb begin
      idle_ok = state == ST_IDLE && !bus.mdu_busy && !bus.flush;
      accept = idle_ok && (grant ? bus.r1_valid : bus.r0_valid);
      sel_op = grant ? bus.r1_op : bus.r0_op;
      sel_rs = grant ? bus.r1_rs : bus.r0_rs;
      sel_rt = grant ? bus.r1_rt : bus.r0_rt;
      bus.r0_ready = idle_ok && !grant;
      bus.r1_ready = idle_ok && grant;
      bus.mdu_start = accept && (is_long_op(sel_op) || sel_op == OP_MTHI || sel_op == OP_MTLO);
      bus.mdu_req = bus.flush;
      bus.mdu_type = accept ? sel_op : '0;
      bus.mdu_rs = accept ? sel_rs : '0;
      bus.mdu_rt = accept ? sel_rt : '0;
      bus.r0_rsp_valid = rsp_valid[0];
      bus.r1_rsp_valid = rsp_valid[1];
      bus.r0_rsp_data = rsp_valid[0] ? rsp_data : '0;
      bus.r1_rsp_data = rsp_valid[1] ? rsp_data : '0;
   end
   // GUARD absorbs the cycle before the MDU raises busy; WAIT then tracks busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         owner <= 1'b0;
         rsp_valid <= '0;
         rsp_data <= '0;
      end else begin
         rsp_valid <= '0;
         rsp_data <= '0;
         if (state == ST_GUARD) state <= ST_WAIT;
         if (state == ST_WAIT && !bus.mdu_busy) begin
            state <= ST_IDLE;
            rsp_valid[owner] <= 1'b1;
         end
         if (accept) begin
            owner <= grant;
            if (is_long_op(sel_op)) state <= ST_GUARD;
            else begin
               rsp_valid[grant] <= 1'b1;
               rsp_data <= (sel_op == OP_MFHI || sel_op == OP_MFLO) ? bus.mdu_out : '0;
            end
         end
      end
   end
`ifdef MD_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         perf_issue_cnt <= perf_issue_cnt + {31'd0, accept};
         perf_stall_cnt <= perf_stall_cnt + {31'd0, (bus.r0_valid || bus.r1_valid) && !accept};
      end
   end
`endif
endmodule
